// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter driving a shared 8-bit register bus.
// Each grant runs one setup phase, then a single write strobe or a timed read capture, then an ack.
module reg_bus_arbiter #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned READ_WAIT = 2
) (
    input  logic       clock50Mhz,
    input  logic       key_restart,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       we0,
    input  logic       we1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       owner
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        ACK
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_q, we_d;
    logic               last_grant, last_grant_d;
    logic [7:0]         bus_addr_d, bus_wdata_d, rdata_d;
    logic               bus_write_d, ack0_d, ack1_d, busy_d, owner_d;
    logic               grant;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

    // Next-state and next-output computation; strobe and acks default to idle-low.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        we_d         = we_q;
        last_grant_d = last_grant;
        bus_addr_d   = bus_addr;
        bus_wdata_d  = bus_wdata;
        rdata_d      = rdata;
        busy_d       = busy;
        owner_d      = owner;
        bus_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    bus_addr_d   = grant ? addr1  : addr0;
                    bus_wdata_d  = grant ? wdata1 : wdata0;
                    we_d         = grant ? we1    : we0;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_W'(SETUP_CYC - 1);
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    if (we_q) begin
                        bus_write_d = 1'b1;
                        state_d     = STROBE;
                    end else begin
                        cnt_d   = CNT_W'(READ_WAIT - 1);
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                state_d = ACK;
            end
            WAIT: begin
                if (cnt == '0) begin
                    rdata_d = bus_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ACK: begin
                ack0_d  = ~owner;
                ack1_d  = owner;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves the pointer on requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_write  <= 1'b0;
            rdata      <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            we_q       <= we_d;
            last_grant <= last_grant_d;
            bus_addr   <= bus_addr_d;
            bus_wdata  <= bus_wdata_d;
            bus_write  <= bus_write_d;
            rdata      <= rdata_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
            owner      <= owner_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: expected transactions are queued when requests are issued
// and retired by a bus/ack monitor; a second instance covers non-default timing.
module tb_reg_bus_arbiter;

    typedef struct {
        bit         id;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       ack0, ack1, bus_write, busy, owner;
    logic [7:0] rdata, bus_addr, bus_wdata, bus_rdata;

    logic       s_req0 = 0, s_req1 = 0, s_we0 = 0, s_we1 = 0;
    logic [7:0] s_addr0 = 0, s_addr1 = 0, s_wdata0 = 0, s_wdata1 = 0;
    logic       s_ack0, s_ack1, s_bus_write, s_busy, s_owner;
    logic [7:0] s_rdata, s_bus_addr, s_bus_wdata, s_bus_rdata;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         strobes = 0;
    int         ack_cnt = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] last_rdata = 8'h00;

    // Register file model: reading an address returns the address itself.
    assign bus_rdata   = bus_addr;
    assign s_bus_rdata = s_bus_addr;

    always #5 clk = ~clk;

    reg_bus_arbiter u_dut (
        .clock50Mhz (clk),
        .key_restart(rst_n),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .we0        (we0),
        .we1        (we1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata      (rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_write  (bus_write),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .owner      (owner)
    );

    reg_bus_arbiter #(.SETUP_CYC(3), .READ_WAIT(5)) u_dut_slow (
        .clock50Mhz (clk),
        .key_restart(rst_n),
        .req0       (s_req0),
        .req1       (s_req1),
        .addr0      (s_addr0),
        .addr1      (s_addr1),
        .wdata0     (s_wdata0),
        .wdata1     (s_wdata1),
        .we0        (s_we0),
        .we1        (s_we1),
        .ack0       (s_ack0),
        .ack1       (s_ack1),
        .rdata      (s_rdata),
        .bus_addr   (s_bus_addr),
        .bus_wdata  (s_bus_wdata),
        .bus_write  (s_bus_write),
        .bus_rdata  (s_bus_rdata),
        .busy       (s_busy),
        .owner      (s_owner)
    );

    // Monitor: latency counts from the first busy cycle to the ack cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            busy_prev = 1'b0;
            strobes   = 0;
        end else begin
            if (busy && !busy_prev) start_cyc = cyc;
            busy_prev = busy;
            if (ack0 && ack1) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_overlap: ack0=%b ack1=%b, required not both high", ack0, ack1);
            end
            if (bus_write) begin
                strobes++;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_unexpected: addr=%h data=%h, required no strobe", bus_addr, bus_wdata);
                end else if (!sb_q[0].we || bus_addr !== sb_q[0].addr || bus_wdata !== sb_q[0].wdata) begin
                    n_fail++;
                    $display("FAIL strobe_bus: addr=%h data=%h, required we=%0d addr=%h data=%h",
                             bus_addr, bus_wdata, sb_q[0].we, sb_q[0].addr, sb_q[0].wdata);
                end
            end
            if (ack0 || ack1) begin
                ack_cnt++;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: ack0=%b ack1=%b, required none", ack0, ack1);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (ack1 !== mon_e.id || owner !== mon_e.id || (cyc - start_cyc) != mon_e.lat ||
                        strobes != (mon_e.we ? 1 : 0) || (!mon_e.we && rdata !== mon_e.rdata)) begin
                        n_fail++;
                        $display("FAIL ack_txn: ack1=%b owner=%b lat=%0d strobes=%0d rdata=%h, required id=%0d lat=%0d strobes=%0d rdata=%h",
                                 ack1, owner, cyc - start_cyc, strobes, rdata, mon_e.id, mon_e.lat,
                                 mon_e.we ? 1 : 0, mon_e.rdata);
                    end
                end
                strobes = 0;
            end
        end
    end

    task automatic push_exp(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.wdata = d; e.rdata = a; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus_addr, bus_wdata, bus_write, ack0, ack1, rdata, busy, owner} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h wdata=%h wr=%b ack=%b%b rdata=%h busy=%b owner=%b, required all 0",
                     bus_addr, bus_wdata, bus_write, ack1, ack0, rdata, busy, owner);
        end
        rst_n = 1'b1;
        last_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write();
        @(negedge clk);
        req0 = 1; addr0 = 8'h21; wdata0 = 8'h5A; we0 = 1;
        push_exp(0, 1, 8'h21, 8'h5A, 3);
        @(negedge clk);
        n_tests++;
        if (bus_addr !== 8'h21 || busy !== 1'b1 || owner !== 1'b0 || bus_write !== 1'b0) begin
            n_fail++;
            $display("FAIL write_grant: addr=%h busy=%b owner=%b wr=%b, required 21 1 0 0", bus_addr, busy, owner, bus_write);
        end
        req0 = 0;
        wait_drain("write");
        n_tests++;
        if (rdata !== last_rdata || bus_addr !== 8'h21 || bus_wdata !== 8'h5A || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_hold: rdata=%h addr=%h wdata=%h busy=%b, required %h 21 5a 0",
                     rdata, bus_addr, bus_wdata, busy, last_rdata);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        req1 = 1; addr1 = 8'h10; we1 = 0;
        push_exp(1, 0, 8'h10, 8'h00, 4);
        @(negedge clk);
        req1 = 0;
        wait_drain("read");
        last_rdata = 8'h10;
        n_tests++;
        if (rdata !== 8'h10) begin
            n_fail++;
            $display("FAIL read_hold: rdata=%h, required 10", rdata);
        end
    endtask

    task automatic test_contention();
        int base;
        test_reset();
        base = ack_cnt;
        req0 = 1; addr0 = 8'h30; wdata0 = 8'hA0; we0 = 1;
        req1 = 1; addr1 = 8'h31; wdata1 = 8'hB1; we1 = 1;
        push_exp(0, 1, 8'h30, 8'hA0, 3);
        push_exp(1, 1, 8'h31, 8'hB1, 3);
        push_exp(0, 1, 8'h30, 8'hA0, 3);
        for (int k = 0; k < 60 && ack_cnt < base + 2; k++) begin
            @(negedge clk);
            #1;
        end
        req1 = 0;
        @(negedge clk);
        #1;
        req0 = 0;
        wait_drain("contention");
        n_tests++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL contention_rdata: rdata=%h, required 00", rdata);
        end
    endtask

    task automatic test_early_drop();
        @(negedge clk);
        req0 = 1; addr0 = 8'h44; wdata0 = 8'h77; we0 = 1;
        push_exp(0, 1, 8'h44, 8'h77, 3);
        @(negedge clk);
        req0 = 0; addr0 = 8'hFF; wdata0 = 8'h00; we0 = 0;
        wait_drain("early_drop");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req1 = 1; addr1 = 8'h55; we1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus_addr, bus_wdata, bus_write, ack0, ack1, rdata, busy, owner} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: addr=%h wdata=%h wr=%b ack=%b%b rdata=%h busy=%b owner=%b, required all 0",
                     bus_addr, bus_wdata, bus_write, ack1, ack0, rdata, busy, owner);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0 || bus_write !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet: ack=%b%b wr=%b, required 0", ack1, ack0, bus_write);
            end
        end
        push_exp(1, 0, 8'h55, 8'h00, 4);
        rst_n = 1'b1;
        @(negedge clk);
        req1 = 0;
        wait_drain("reset_mid");
    endtask

    task automatic test_param_sweep();
        int cnt;
        int strb;
        bit got;
        @(negedge clk);
        s_req1 = 1; s_addr1 = 8'h66; s_we1 = 0;
        cnt = 0; got = 0; strb = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) s_req1 = 0;
            if (s_bus_write) strb++;
            if (s_ack1) got = 1;
        end
        n_tests++;
        if (!got || cnt - 1 != 9 || s_rdata !== 8'h66 || strb != 0 || s_ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_read: got=%0d lat=%0d rdata=%h strobes=%0d, required 1 9 66 0", got, cnt - 1, s_rdata, strb);
        end
        @(negedge clk);
        s_req0 = 1; s_addr0 = 8'h77; s_wdata0 = 8'h12; s_we0 = 1;
        cnt = 0; got = 0; strb = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) s_req0 = 0;
            if (s_bus_write) begin
                strb++;
                n_tests++;
                if (s_bus_addr !== 8'h77 || s_bus_wdata !== 8'h12) begin
                    n_fail++;
                    $display("FAIL sweep_strobe: addr=%h data=%h, required 77 12", s_bus_addr, s_bus_wdata);
                end
            end
            if (s_ack0) got = 1;
        end
        n_tests++;
        if (!got || cnt - 1 != 5 || strb != 1 || s_rdata !== 8'h66) begin
            n_fail++;
            $display("FAIL sweep_write: got=%0d lat=%0d strobes=%0d rdata=%h, required 1 5 1 66", got, cnt - 1, strb, s_rdata);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_early_drop();
        test_reset_mid();
        test_param_sweep();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles the address and data are driven before the strobe or read wait (legal 1..15).
REQ-002 SHALL have parameter READ_WAIT, default 2: cycles between the end of setup and the capture of bus_rdata (legal 1..15).
REQ-003 SHALL have port clock50Mhz  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port key_restart  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1 each  transaction request from requester 0 (JTAG) / requester 1 (Ethernet).
REQ-006 SHALL have ports addr0/addr1  input  8 each  requested register address.
REQ-007 SHALL have ports wdata0/wdata1  input  8 each  write data.
REQ-008 SHALL have ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-009 SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse to the requester.
REQ-010 SHALL have port rdata  output  8  captured read data, shared by both requesters, valid while ack0 or ack1 is high.
REQ-011 SHALL have port bus_addr  output  8  shared register-bus address.
REQ-012 SHALL have port bus_wdata  output  8  shared register-bus write data.
REQ-013 SHALL have port bus_write  output  1  one-cycle write strobe.
REQ-014 SHALL have port bus_rdata  input  8  read-mux output, combinational from bus_addr.
REQ-015 SHALL have ports busy (output 1) and owner (output 1): transaction in progress / index of the current or last granted requester.

Function
REQ-016 SHALL implement the states IDLE, SETUP, STROBE, WAIT and ACK; all outputs SHALL be registered.
REQ-017 In IDLE, with any reqN high at an edge, SHALL grant, latch addrN/wdataN/weN into bus_addr/bus_wdata/internal we, set owner and busy, and enter SETUP.
REQ-018 Arbitration SHALL be round-robin: if both requests are high, the requester not granted last wins; a single request wins immediately.
REQ-019 SETUP SHALL last exactly SETUP_CYC cycles with bus_write=0, then go to STROBE on a write or WAIT on a read.
REQ-020 STROBE SHALL assert bus_write for exactly one cycle and then go to ACK.
REQ-021 WAIT SHALL last READ_WAIT cycles; on its last edge it SHALL load bus_rdata into rdata and go to ACK.
REQ-022 ACK SHALL pulse ack[owner] for one cycle, clear busy, and return to IDLE.
REQ-023 Latency from the req-sampling edge to the cycle ack is high: write = SETUP_CYC+2 cycles; read = SETUP_CYC+READ_WAIT+1 cycles.
REQ-024 Requests SHALL NOT be sampled outside IDLE; a losing or late request waits, and no request is dropped while its req stays high.
REQ-025 A req deasserted after grant SHALL NOT abort the transaction; the transaction completes and ack is still pulsed.
REQ-026 A req still high in IDLE after its ack SHALL be treated as a new transaction; the round-robin pointer then favours the other requester.
REQ-027 Changes to addrN/wdataN/weN after grant SHALL NOT affect the bus.
REQ-028 In IDLE, bus_addr and bus_wdata SHALL hold their last values; rdata SHALL hold until the next read capture and SHALL NOT change on writes.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle; at most one transaction SHALL be outstanding.

Reset
REQ-030 While key_restart=0 (asynchronous), the block SHALL force: state IDLE; bus_addr=0; bus_wdata=0; bus_write=0; ack0=ack1=0; rdata=0; busy=0; owner=0; round-robin pointer = last-granted 1, so requester 0 wins the first tie.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no strobe and no ack; after release, the block SHALL resample requests from IDLE.

Verification
REQ-032 Write, defaults: req0=1, addr0=8'h21, wdata0=8'h5A, we0=1 -> bus_addr=8'h21 one cycle after grant; bus_write high exactly 1 cycle with bus_wdata=8'h5A; ack0 3 cycles after the sampling edge.
REQ-033 Read: req1=1, addr1=8'h10, we1=0, bus_rdata returns 8'h10 for that address -> ack1 4 cycles after sampling; rdata=8'h10; bus_write never high.
REQ-034 Contention: req0 and req1 high together from reset, both writes -> requester 0 served first, then requester 1, then requester 0 again if still requesting; no overlap of acks.
REQ-035 Early drop: req0 pulsed for 1 cycle with a write, then addr0 changed to 8'hFF -> strobe still occurs at the latched address; ack0 still pulses.
REQ-036 Reset mid-operation: key_restart low during WAIT -> all outputs go to the REQ-030 values immediately; no ack; a request held after release is granted normally.
REQ-037 Parameter sweep: SETUP_CYC=3, READ_WAIT=5 -> read ack at 9 cycles, write ack at 5 cycles.
